// File: rtl/lives_controller.sv
// -----------------------------------------------------------------------------
// lives_controller
//   Owns the player's life count for the HUD and player sprite layer.
//   Consumes hit / bonus / restart pulses from the game logic, runs a
//   frame-timed invulnerability window with a blinking sprite after every
//   non-fatal hit, and flags game over when a hit lands on the last life.
//   Single clock domain (vga_clk); every output comes straight from a flop.
// -----------------------------------------------------------------------------
module lives_controller #(
    parameter int unsigned MAX_LIVES     = 3,   // saturation ceiling, <= 7
    parameter int unsigned START_LIVES   = 3,   // loaded at reset / restart
    parameter int unsigned INVULN_FRAMES = 120, // invulnerability length, >= 1
    parameter int unsigned BLINK_FRAMES  = 8    // blink half-period in frames, >= 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       hit,
    input  logic       bonus,
    input  logic       restart,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       invuln,
    output logic       player_visible,
    output logic       lives_changed
);

    // Counter widths: inv_cnt must hold INVULN_FRAMES itself, blink_cnt only
    // needs 0..BLINK_FRAMES-1 but never collapses below one bit.
    localparam int unsigned INV_W   = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [2:0]         MAX_L      = 3'(MAX_LIVES);
    localparam logic [2:0]         START_L    = 3'(START_LIVES);
    localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES);
    localparam logic [INV_W-1:0]   INV_LAST   = INV_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [2:0]         lives_q,     lives_d;
    logic [INV_W-1:0]   inv_cnt_q,   inv_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               visible_q,   visible_d;
    logic               over_q,      over_d;
    logic               invuln_q,    invuln_d;
    logic               changed_q,   changed_d;

    // Next-state logic: at most one event is acted on per cycle, chosen in
    // the order restart > hit > bonus > frame_start.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the branches below leaves one unassigned and infers a latch.
        state_d     = state_q;
        lives_d     = lives_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;

        if (restart) begin
            // New game: everything else arriving this cycle is discarded.
            state_d     = ST_ALIVE;
            lives_d     = START_L;
            inv_cnt_d   = '0;
            blink_cnt_d = '0;
            visible_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_ALIVE: begin
                    if (hit) begin
                        // A hit always wins over a simultaneous bonus.
                        if (lives_q != 3'd0) begin
                            lives_d     = lives_q - 3'd1;
                            state_d     = ST_INVULN;
                            inv_cnt_d   = INV_LOAD;
                            blink_cnt_d = '0;
                            visible_d   = 1'b0;
                        end else begin
                            state_d   = ST_OVER;
                            visible_d = 1'b0;
                        end
                    end else if (bonus) begin
                        if (lives_q < MAX_L) begin
                            lives_d = lives_q + 3'd1;
                        end
                    end
                    // frame_start has no effect while plainly alive.
                end

                ST_INVULN: begin
                    // Hits are ignored while invulnerable.
                    if (bonus) begin
                        if (lives_q < MAX_L) begin
                            lives_d = lives_q + 3'd1;
                        end
                    end else if (frame_start) begin
                        if (inv_cnt_q == INV_LAST) begin
                            // Window expires: sprite back on solid.
                            state_d     = ST_ALIVE;
                            inv_cnt_d   = '0;
                            blink_cnt_d = '0;
                            visible_d   = 1'b1;
                        end else begin
                            inv_cnt_d = inv_cnt_q - INV_LAST;
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_d = '0;
                                visible_d   = ~visible_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                            end
                        end
                    end
                end

                ST_OVER: begin
                    // Frozen until restart or reset.
                end

                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    // Output flags are decoded from the next state so they land in flops
    // alongside the state they describe.
    always_comb begin
        over_d    = (state_d == ST_OVER);
        invuln_d  = (state_d == ST_INVULN);
        changed_d = (lives_d != lives_q);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        // NOTE: every flop here is reset, so the HUD sees defined values the
        // moment reset_n drops, even mid-invulnerability, without a clock.
        if (!reset_n) begin
            state_q     <= ST_ALIVE;
            lives_q     <= START_L;
            inv_cnt_q   <= '0;
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
            over_q      <= 1'b0;
            invuln_q    <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            lives_q     <= lives_d;
            inv_cnt_q   <= inv_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
            over_q      <= over_d;
            invuln_q    <= invuln_d;
            changed_q   <= changed_d;
        end
    end

    assign lives          = lives_q;
    assign game_over      = over_q;
    assign invuln         = invuln_q;
    assign player_visible = visible_q;
    assign lives_changed  = changed_q;

endmodule

// File: tb/tb_lives_controller.sv
// -----------------------------------------------------------------------------
// tb_lives_controller
//   Directed scenarios followed by random event traffic. Expected values come
//   from a model that tracks lives, a game-over flag and the number of frames
//   elapsed since the last hit; sprite visibility is derived arithmetically
//   from that elapsed-frame count.
// -----------------------------------------------------------------------------
module tb_lives_controller;

    localparam int MAX_LIVES     = 3;
    localparam int START_LIVES   = 3;
    localparam int INVULN_FRAMES = 4;
    localparam int BLINK_FRAMES  = 2;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       hit = 1'b0;
    logic       bonus = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] lives;
    logic       game_over;
    logic       invuln;
    logic       player_visible;
    logic       lives_changed;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_lives;
    bit m_over;
    bit m_inv;
    int m_elapsed;
    bit m_chg;

    lives_controller #(
        .MAX_LIVES    (MAX_LIVES),
        .START_LIVES  (START_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .vga_clk       (vga_clk),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .hit           (hit),
        .bonus         (bonus),
        .restart       (restart),
        .lives         (lives),
        .game_over     (game_over),
        .invuln        (invuln),
        .player_visible(player_visible),
        .lives_changed (lives_changed)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_visible();
        if (m_over) return 1'b0;
        if (!m_inv) return 1'b1;
        // Hidden for the first BLINK_FRAMES frames, then alternating.
        return ((m_elapsed / BLINK_FRAMES) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_lives   = START_LIVES;
        m_over    = 1'b0;
        m_inv     = 1'b0;
        m_elapsed = 0;
        m_chg     = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit h, input bit b, input bit f);
        int old;
        old = m_lives;
        if (r) begin
            m_lives = START_LIVES; m_over = 0; m_inv = 0; m_elapsed = 0;
        end else if (m_over) begin
            // nothing moves once the game is over
        end else if (h && !m_inv) begin
            if (m_lives > 0) begin
                m_lives--; m_inv = 1; m_elapsed = 0;
            end else begin
                m_over = 1;
            end
        end else if (b) begin
            m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
        end else if (f && m_inv) begin
            m_elapsed++;
            if (m_elapsed == INVULN_FRAMES) begin
                m_inv = 0; m_elapsed = 0;
            end
        end
        m_chg = (m_lives != old);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".lives"},     int'(lives),          m_lives);
        check({tag, ".game_over"}, int'(game_over),      int'(m_over));
        check({tag, ".invuln"},    int'(invuln),         int'(m_inv));
        check({tag, ".visible"},   int'(player_visible), int'(model_visible()));
        check({tag, ".changed"},   int'(lives_changed),  int'(m_chg));
    endtask

    // Drive one cycle of events (called at edge+1), sample at the next edge+1.
    task automatic step(input bit r, input bit h, input bit b, input bit f, input string tag);
        restart = r; hit = h; bonus = b; frame_start = f;
        @(posedge vga_clk);
        #1;
        model_step(r, h, b, f);
        check_all(tag);
        restart = 0; hit = 0; bonus = 0; frame_start = 0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, tag);
    endtask

    task automatic frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, tag);
            idle(1, tag);
        end
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        check_all("reset");
        check("reset.lives_const", int'(lives), 3);
        #20 reset_n = 1'b1;
        @(posedge vga_clk);
        #1;

        // Hit at full lives, then a second hit five cycles later is ignored.
        step(0, 1, 0, 0, "hit1");
        check("hit1.lives_const", int'(lives), 2);
        check("hit1.changed_const", int'(lives_changed), 1);
        idle(4, "inv_idle");
        step(0, 1, 0, 0, "hit_ignored");
        check("hit_ignored.lives_const", int'(lives), 2);

        // Four frames: visible after frame 2, alive and solid after frame 4.
        step(0, 0, 0, 1, "frame1");
        check("frame1.visible_const", int'(player_visible), 0);
        step(0, 0, 0, 1, "frame2");
        check("frame2.visible_const", int'(player_visible), 1);
        step(0, 0, 0, 1, "frame3");
        step(0, 0, 0, 1, "frame4");
        check("frame4.invuln_const", int'(invuln), 0);
        check("frame4.visible_const", int'(player_visible), 1);
        step(0, 0, 0, 1, "frame_alive");

        // Bonus up to the ceiling, then saturation.
        step(0, 0, 1, 0, "bonus_inc");
        step(0, 0, 1, 0, "bonus_sat");
        check("bonus_sat.changed_const", int'(lives_changed), 0);

        // Down to the last life, including hit+bonus in the same cycle.
        step(0, 1, 0, 0, "hit_to2");
        frames(INVULN_FRAMES, "exp2");
        step(0, 1, 1, 0, "hit_bonus");
        check("hit_bonus.lives_const", int'(lives), 1);
        frames(INVULN_FRAMES, "exp1");
        step(0, 1, 0, 0, "hit_to0");
        frames(INVULN_FRAMES, "exp0");
        step(0, 1, 0, 0, "fatal");
        check("fatal.game_over_const", int'(game_over), 1);
        step(0, 1, 0, 0, "over_hit");
        step(0, 0, 1, 0, "over_bonus");
        step(0, 0, 0, 1, "over_frame");

        // Restart with a simultaneous hit: the hit is discarded.
        step(1, 1, 0, 0, "restart");
        check("restart.changed_const", int'(lives_changed), 1);
        step(1, 0, 0, 0, "restart_same");

        // Asynchronous reset in the middle of an invulnerability window.
        step(0, 1, 0, 0, "hit_pre_rst");
        step(0, 0, 0, 1, "frame_pre_rst");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(posedge vga_clk);
        #1;
        check_all("post_rst");

        // Random event traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, h, b, f;
            int sel;
            r = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 9);
            h = (sel <= 1);
            b = (sel == 2);
            f = (sel >= 3 && sel <= 6);
            if ($urandom_range(0, 7) == 0) begin
                h = h | $urandom_range(0, 1);
                b = b | $urandom_range(0, 1);
                f = f | $urandom_range(0, 1);
            end
            step(r, h, b, f, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
